// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage and its fetch queue.
// Used by inst_fetch.sv, whose misalignment check is enabled with INST_FETCH_MISALIGN_CHK_EN.
package inst_fetch_pkg;

  localparam int ROM_ADDR_W  = 13;
  localparam int FETCH_DEPTH = 2;

  typedef logic [12:0] rom_addr_t;
  typedef logic [31:0] word;

  localparam rom_addr_t RESET_PC = '0;

  typedef struct packed {
    rom_addr_t pc;
    word       inst;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_fetch_fetch_queue.sv
// Small power-of-two FIFO that holds fetched {pc, inst} packets between fetch and decode.
// Flush has priority over push and pop; the head reads zero while the queue is empty.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH  = FETCH_DEPTH,
  parameter int DATA_W = $bits(fetch_pkt_t),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; the empty check below keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the ROM address, queues fetched words for decode and takes redirects.
// Define INST_FETCH_MISALIGN_CHK_EN to flag redirect targets that are not word aligned.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              ADDR_W   = ROM_ADDR_W,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = inst_fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic              misalign_err
);

  localparam int PKT_W = ADDR_W + 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop;
  logic              q_full, q_empty;
  logic [PKT_W-1:0]  q_head;
  logic [CNT_W-1:0]  unused_q_count;

  // A redirect blocks both queue ports; a pop frees a slot for a same-cycle push.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & (~q_full | pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (PKT_W)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({pc_q, rom_data}),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .count     (unused_q_count)
  );

  assign rom_addr  = pc_q;
  assign out_valid = ~q_empty;
  assign out_pc    = q_head[PKT_W-1:32];
  assign out_inst  = q_head[31:0];

`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  // Without the check the low target bits are simply dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a queue-based model of the fetch rules.
// Expectations for misalign_err follow INST_FETCH_MISALIGN_CHK_EN as compiled.
module tb_inst_fetch;

  localparam int MODEL_DEPTH = 2;
`ifdef INST_FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [12:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [12:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_pc;
  logic [31:0] out_inst;
  logic        misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected PC and the PCs sitting in the queue, oldest first.
  logic [12:0] m_pc;
  logic [12:0] m_q[$];
  bit          m_mis;
  bit          m_known = 1'b0;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-derived ROM contents so a wrong word is always visible.
  function automatic logic [31:0] rom_word(input logic [12:0] a);
    return {a, 3'b101, a ^ 13'h1A5A, 3'b010};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, drive inputs, then advance the model.
  task automatic applyStimulus(input bit r, input bit rv, input logic [12:0] rpc, input bit rdy);
    @(negedge clk);
    if (m_known) begin
      checkOutput("rom_addr", {19'd0, rom_addr}, {19'd0, m_pc});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      checkOutput("out_pc", {19'd0, out_pc}, (m_q.size() > 0) ? {19'd0, m_q[0]} : 32'd0);
      checkOutput("out_inst", out_inst, (m_q.size() > 0) ? rom_word(m_q[0]) : 32'd0);
      checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    end
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (r) begin
      m_q.delete();
      m_pc    = 13'h0000;
      m_mis   = 1'b0;
      m_known = 1'b1;
    end else if (rv) begin
      m_q.delete();
      m_pc  = rpc & 13'h1FFC;
      m_mis = MIS_EN && (rpc[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (m_q.size() < MODEL_DEPTH) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 13'd4;
      end
    end
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Scenario 1: free-running fetch after reset.
    applyStimulus(1, 0, 13'h0, 1);
    applyStimulus(1, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t1_reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t1_reset_addr", {19'd0, rom_addr}, 32'd0);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t1_first_pc", {19'd0, out_pc}, 32'h0);
    checkOutput("t1_first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 13'h0, 1);

    // Scenario 2: backpressure right after reset.
    applyStimulus(1, 0, 13'h0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 13'h0, 0);
    afterEdge();
    checkOutput("t2_stall_addr", {19'd0, rom_addr}, 32'h008);
    checkOutput("t2_head_pc", {19'd0, out_pc}, 32'h000);

    // Scenario 3: redirect while full with decode ready.
    applyStimulus(0, 1, 13'h100, 1);
    afterEdge();
    checkOutput("t3_flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t3_target_addr", {19'd0, rom_addr}, 32'h100);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t3_target_pc", {19'd0, out_pc}, 32'h100);

    // Scenario 4: PC wraps at the top of the ROM.
    applyStimulus(0, 1, 13'h1FF8, 1);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t4_pc_1ff8", {19'd0, out_pc}, 32'h1FF8);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t4_pc_1ffc", {19'd0, out_pc}, 32'h1FFC);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t4_pc_wrap", {19'd0, out_pc}, 32'h0000);

    // Scenario 5: back-to-back redirects, last one wins.
    applyStimulus(0, 1, 13'h040, 1);
    applyStimulus(0, 1, 13'h080, 1);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t5_last_wins", {19'd0, out_pc}, 32'h080);

    // Scenario 6: misaligned redirect target.
    applyStimulus(0, 1, 13'h102, 1);
    afterEdge();
    checkOutput("t6_mis_pulse", {31'd0, misalign_err}, {31'd0, MIS_EN});
    checkOutput("t6_aligned_addr", {19'd0, rom_addr}, 32'h100);
    applyStimulus(0, 0, 13'h0, 1);
    afterEdge();
    checkOutput("t6_mis_clear", {31'd0, misalign_err}, 32'd0);
    checkOutput("t6_target_pc", {19'd0, out_pc}, 32'h100);

    // Reset wins over a simultaneous redirect.
    applyStimulus(1, 1, 13'h301, 1);
    afterEdge();
    checkOutput("rst_over_redirect", {19'd0, rom_addr}, 32'h000);
    checkOutput("rst_over_mis", {31'd0, misalign_err}, 32'd0);

    // Random mix of stalls, redirects and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                    13'($urandom), ($urandom_range(3) != 0));
    end
    applyStimulus(0, 0, 13'h0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
